alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have port clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port btnc  input  1  one-shot pulse: enter or leave alarm set / stop ringing.
REQ-004 SHALL have port btnr  input  1  one-shot pulse: toggle alarm_on / move to next field.
REQ-005 SHALL have port btnu  input  1  one-shot pulse: increment field / snooze.
REQ-006 SHALL have port clk_set_busy  input  1  time-set mode of the clock controller is active.
REQ-007 SHALL have port tick_1hz  input  1  one-cycle pulse, once per second.
REQ-008 SHALL have port mask_1hz  input  1  50% duty 1 Hz blink mask.
REQ-009 SHALL have ports cur_hour  input  5 (0-23), cur_min  input  6 (0-59), cur_sec  input  6 (0-59), giving the current time.
REQ-010 SHALL have outputs alarm_hour  5 and alarm_min  6, the stored alarm time.
REQ-011 SHALL have output alarm_on  1, alarm armed.
REQ-012 SHALL have output alarm_disp  1, display shows the alarm time instead of the current time.
REQ-013 SHALL have outputs disp_en_h  1 and disp_en_m  1, hour and minute digit blink enables.
REQ-014 SHALL have output ringing  1, in the RING state.
REQ-015 SHALL have output buzzer  1, gated buzzer drive.

Function
REQ-016 SHALL implement the FSM states IDLE, SET_H, SET_M, RING and SNOOZE, all registered; each transition SHALL take effect on the clock edge that samples the pulse, so outputs update 1 cycle later.
REQ-017 When more than one button pulses in the same cycle, priority SHALL be btnc > btnr > btnu; only the winning button SHALL act.
REQ-018 IDLE, with clk_set_busy=0: btnc -> SET_H; btnr toggles alarm_on; btnu is ignored.
REQ-019 IDLE, with clk_set_busy=1: all buttons SHALL be ignored.
REQ-020 SET_H: btnu -> alarm_hour+1, wrapping 23->0; btnr -> SET_M; btnc -> IDLE.
REQ-021 SET_M: btnu -> alarm_min+1, wrapping 59->0; btnr -> SET_H; btnc -> IDLE.
REQ-022 Match condition: state=IDLE, alarm_on=1, tick_1hz=1, cur_hour=alarm_hour, cur_min=alarm_min, cur_sec=0 -> RING, with the ring counter cleared to 0.
REQ-023 A match SHALL be ignored in SET_H and SET_M; no deferred ring SHALL be generated afterwards.
REQ-024 A button winning in IDLE in the same cycle as a match SHALL take precedence over the match.
REQ-025 RING: each tick_1hz increments the 6-bit ring counter; when the counter reaches 59 and a tick arrives (60 s total) -> IDLE.
REQ-026 RING: btnc -> IDLE (stop); btnu -> SNOOZE with the 9-bit snooze counter cleared; btnr is ignored.
REQ-027 SNOOZE: each tick increments the snooze counter; when the counter reaches 299 and a tick arrives (300 s total) -> RING with the ring counter cleared.
REQ-028 SNOOZE: btnc -> IDLE (cancel); btnr and btnu are ignored.
REQ-029 Clearing alarm_on SHALL require IDLE, so RING and SNOOZE are left only via btnc or timeout.
REQ-030 clk_set_busy SHALL affect only IDLE.
REQ-031 alarm_disp SHALL be 1 in SET_H and SET_M, and 0 otherwise.
REQ-032 disp_en_h SHALL equal mask_1hz in SET_H and 1 otherwise; disp_en_m SHALL equal mask_1hz in SET_M and 1 otherwise (combinational from mask_1hz).
REQ-033 ringing SHALL be 1 only in RING; buzzer SHALL equal ringing AND mask_1hz.
REQ-034 A tick_1hz arriving in the same cycle as a btnc or btnu transition out of RING or SNOOZE SHALL be discarded and SHALL NOT count.

Reset
REQ-035 rst_n=0 sampled on a rising edge SHALL force: state IDLE, alarm_hour=0, alarm_min=0, alarm_on=0, ring counter=0, snooze counter=0.
REQ-036 After reset, outputs SHALL read: alarm_disp=0, ringing=0, buzzer=0, disp_en_h=disp_en_m=1.
REQ-037 Reset SHALL override every other input, including when asserted mid-RING or mid-SNOOZE.

Verification
REQ-038 Set sequence: btnc, btnu x7, btnr, btnu x30, btnc -> alarm_hour=7, alarm_min=30, alarm_disp returns to 0.
REQ-039 Hour wrap: in SET_H, btnu x25 -> alarm_hour=1; minute wrap: in SET_M, btnu x61 -> alarm_min=1.
REQ-040 Ring and timeout: alarm 07:30 armed, time stepped to 07:30:00 with tick -> ringing=1 next cycle, buzzer follows mask_1hz; 60 ticks later -> ringing=0.
REQ-041 Snooze: in RING, btnu -> ringing=0; after 300 ticks -> ringing=1; btnc -> IDLE with alarm_on still 1.
REQ-042 Blocking: clk_set_busy=1 and btnc -> state stays IDLE; match while in SET_M -> no ring; btnc+btnr in the same cycle in IDLE -> SET_H with alarm_on unchanged.
REQ-043 Reset mid-RING: rst_n low for 3 cycles -> all outputs at reset values, alarm_on=0.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm controller: stores an alarm time, arms/disarms it, rings on a match,
// and supports a 300 s snooze and a 60 s automatic ring timeout.
module alarm_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnc,
  input  logic       btnr,
  input  logic       btnu,
  input  logic       clk_set_busy,
  input  logic       tick_1hz,
  input  logic       mask_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       alarm_on,
  output logic       alarm_disp,
  output logic       disp_en_h,
  output logic       disp_en_m,
  output logic       ringing,
  output logic       buzzer
);

  typedef enum logic [2:0] {IDLE, SET_H, SET_M, RING, SNOOZE} state_e;

  state_e     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic       on_q, on_d;
  logic [5:0] ring_cnt_q, ring_cnt_d;
  logic [8:0] snz_cnt_q, snz_cnt_d;
  logic       disp_q, ringing_q;
  logic       match;

  assign match = on_q && tick_1hz && (cur_hour == hour_q) &&
                 (cur_min == min_q) && (cur_sec == 6'd0);

  always_comb begin
    state_d    = state_q;
    hour_d     = hour_q;
    min_d      = min_q;
    on_d       = on_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    case (state_q)
      // Buttons beat a simultaneous match; btnu alone does nothing here.
      IDLE: begin
        if (!clk_set_busy && btnc) begin
          state_d = SET_H;
        end else if (!clk_set_busy && btnr) begin
          on_d = !on_q;
        end else if (match) begin
          state_d    = RING;
          ring_cnt_d = 6'd0;
        end
      end
      SET_H: begin
        if (btnc)      state_d = IDLE;
        else if (btnr) state_d = SET_M;
        else if (btnu) hour_d  = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      end
      SET_M: begin
        if (btnc)      state_d = IDLE;
        else if (btnr) state_d = SET_H;
        else if (btnu) min_d   = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      end
      // A tick coinciding with a button exit is dropped by the else-chain.
      RING: begin
        if (btnc) begin
          state_d = IDLE;
        end else if (btnu) begin
          state_d   = SNOOZE;
          snz_cnt_d = 9'd0;
        end else if (tick_1hz) begin
          if (ring_cnt_q == 6'd59) state_d = IDLE;
          else                     ring_cnt_d = ring_cnt_q + 6'd1;
        end
      end
      SNOOZE: begin
        if (btnc) begin
          state_d = IDLE;
        end else if (tick_1hz) begin
          if (snz_cnt_q == 9'd299) begin
            state_d    = RING;
            ring_cnt_d = 6'd0;
          end else begin
            snz_cnt_d = snz_cnt_q + 9'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      on_q       <= 1'b0;
      ring_cnt_q <= 6'd0;
      snz_cnt_q  <= 9'd0;
      disp_q     <= 1'b0;
      ringing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      on_q       <= on_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      disp_q     <= (state_d == SET_H) || (state_d == SET_M);
      ringing_q  <= (state_d == RING);
    end
  end

  assign alarm_hour = hour_q;
  assign alarm_min  = min_q;
  assign alarm_on   = on_q;
  assign alarm_disp = disp_q;
  assign ringing    = ringing_q;
  assign buzzer     = ringing_q & mask_1hz;
  assign disp_en_h  = (state_q == SET_H) ? mask_1hz : 1'b1;
  assign disp_en_m  = (state_q == SET_M) ? mask_1hz : 1'b1;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: expectations queued as stimulus is applied,
// then popped and checked against the sampled outputs.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, btnc, btnr, btnu, clk_set_busy, tick_1hz, mask_1hz;
  logic [4:0] cur_hour;
  logic [5:0] cur_min, cur_sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_on, alarm_disp, disp_en_h, disp_en_m, ringing, buzzer;

  int checks = 0;
  int failures = 0;

  localparam int F_HOUR = 0, F_MIN = 1, F_ON = 2, F_DISP = 3, F_RING = 4,
                 F_BUZZ = 5, F_ENH = 6, F_ENM = 7;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  alarm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .btnc(btnc), .btnr(btnr), .btnu(btnu),
    .clk_set_busy(clk_set_busy), .tick_1hz(tick_1hz), .mask_1hz(mask_1hz),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_on(alarm_on),
    .alarm_disp(alarm_disp), .disp_en_h(disp_en_h), .disp_en_m(disp_en_m),
    .ringing(ringing), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      F_HOUR:  return {27'd0, alarm_hour};
      F_MIN:   return {26'd0, alarm_min};
      F_ON:    return {31'd0, alarm_on};
      F_DISP:  return {31'd0, alarm_disp};
      F_RING:  return {31'd0, ringing};
      F_BUZZ:  return {31'd0, buzzer};
      F_ENH:   return {31'd0, disp_en_h};
      default: return {31'd0, disp_en_m};
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input int val);
    sb.push_back('{tag, sel, val});
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit c, input bit r, input bit u, input bit t);
    btnc = c; btnr = r; btnu = u; tick_1hz = t;
    step();
    btnc = 0; btnr = 0; btnu = 0; tick_1hz = 0;
  endtask

  task automatic presses_u(input int n);
    for (int i = 0; i < n; i++) press(0, 0, 1, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) press(0, 0, 0, 1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) step();
    rst_n = 1'b1;
  endtask

  task automatic expect_reset_vals(input string tag);
    expect_v({tag, "_hour"}, F_HOUR, 0);
    expect_v({tag, "_min"},  F_MIN, 0);
    expect_v({tag, "_on"},   F_ON, 0);
    expect_v({tag, "_disp"}, F_DISP, 0);
    expect_v({tag, "_ring"}, F_RING, 0);
    expect_v({tag, "_buzz"}, F_BUZZ, 0);
    expect_v({tag, "_enh"},  F_ENH, 1);
    expect_v({tag, "_enm"},  F_ENM, 1);
  endtask

  initial begin
    rst_n = 1; btnc = 0; btnr = 0; btnu = 0; clk_set_busy = 0;
    tick_1hz = 0; mask_1hz = 1;
    cur_hour = 5'd12; cur_min = 6'd0; cur_sec = 6'd0;
    step();

    do_reset(2);
    expect_reset_vals("reset");
    check();

    // Wrap-around of hour and minute fields
    press(1, 0, 0, 0);
    presses_u(23);
    expect_v("hour_23", F_HOUR, 23); check();
    presses_u(1);
    expect_v("hour_wrap0", F_HOUR, 0); check();
    presses_u(1);
    expect_v("hour_x25", F_HOUR, 1); check();
    press(0, 1, 0, 0);
    presses_u(59);
    expect_v("min_59", F_MIN, 59); check();
    presses_u(2);
    expect_v("min_x61", F_MIN, 1);
    expect_v("wrap_hour_kept", F_HOUR, 1); check();
    press(1, 0, 0, 0);

    // Set sequence 07:30 from a clean state
    do_reset(2);
    press(1, 0, 0, 0);
    expect_v("seth_disp", F_DISP, 1); check();
    mask_1hz = 0;
    expect_v("seth_enh_blink", F_ENH, 0);
    expect_v("seth_enm_solid", F_ENM, 1); check();
    mask_1hz = 1;
    presses_u(7);
    press(0, 1, 0, 0);
    mask_1hz = 0;
    expect_v("setm_enh_solid", F_ENH, 1);
    expect_v("setm_enm_blink", F_ENM, 0); check();
    mask_1hz = 1;
    presses_u(30);
    press(1, 0, 0, 0);
    expect_v("set_hour", F_HOUR, 7);
    expect_v("set_min", F_MIN, 30);
    expect_v("set_disp_back", F_DISP, 0); check();

    // Arm, then priority btnc over btnr in IDLE
    press(0, 1, 0, 0);
    expect_v("arm_on", F_ON, 1); check();
    press(1, 1, 0, 0);
    expect_v("prio_cr_disp", F_DISP, 1);
    expect_v("prio_cr_on", F_ON, 1); check();
    // In SET_H, btnr beats btnu: field moves, hour untouched
    press(0, 1, 1, 0);
    mask_1hz = 0;
    expect_v("prio_ru_hour", F_HOUR, 7);
    expect_v("prio_ru_enm", F_ENM, 0); check();
    mask_1hz = 1;
    press(1, 0, 0, 0);

    // clk_set_busy blocks IDLE buttons
    clk_set_busy = 1;
    press(1, 0, 0, 0);
    expect_v("busy_btnc", F_DISP, 0); check();
    press(0, 1, 0, 0);
    expect_v("busy_btnr", F_ON, 1); check();
    clk_set_busy = 0;

    // Match while in SET_M is ignored and not deferred
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    cur_hour = 5'd7; cur_min = 6'd30; cur_sec = 6'd0;
    press(0, 0, 0, 1);
    expect_v("setm_match_ring", F_RING, 0); check();
    press(1, 0, 0, 0);
    cur_sec = 6'd1;
    ticks(2);
    expect_v("no_deferred_ring", F_RING, 0); check();

    // Ring and 60 s timeout
    cur_sec = 6'd0;
    press(0, 0, 0, 1);
    expect_v("ring_start", F_RING, 1);
    expect_v("ring_buzz_hi", F_BUZZ, 1); check();
    cur_sec = 6'd1;
    mask_1hz = 0;
    expect_v("ring_buzz_lo", F_BUZZ, 0); check();
    mask_1hz = 1;
    press(0, 1, 0, 0);
    expect_v("ring_btnr_ign", F_RING, 1);
    expect_v("ring_btnr_on", F_ON, 1); check();
    ticks(59);
    expect_v("ring_59", F_RING, 1); check();
    ticks(1);
    expect_v("ring_timeout", F_RING, 0);
    expect_v("ring_timeout_on", F_ON, 1); check();

    // Snooze for 300 s, then cancel
    cur_sec = 6'd0;
    press(0, 0, 0, 1);
    expect_v("ring2_start", F_RING, 1); check();
    cur_sec = 6'd1;
    press(0, 0, 1, 1);
    expect_v("snooze_enter", F_RING, 0); check();
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    ticks(299);
    expect_v("snooze_299", F_RING, 0); check();
    ticks(1);
    expect_v("snooze_rering", F_RING, 1); check();
    press(1, 0, 0, 0);
    expect_v("stop_ring", F_RING, 0);
    expect_v("stop_on_kept", F_ON, 1);
    expect_v("stop_disp", F_DISP, 0); check();

    // Reset mid-RING
    cur_sec = 6'd0;
    press(0, 0, 0, 1);
    expect_v("ring3_start", F_RING, 1); check();
    btnu = 1; tick_1hz = 1;
    do_reset(3);
    btnu = 0; tick_1hz = 0;
    expect_reset_vals("rst_ring");
    check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
